// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller.
//   state_t   : controller FSM encoding (2'd3 unused, recovers to IDLE)
//   MEM_OP_*  : captured operation codes
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the MEM-stage request side and the SRAM side of the controller.
//   slave  : the controller (samples requests, drives SRAM, returns load data)
//   master : the pipeline + SRAM environment around it
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       addr_in;
  logic [31:0]       wdata_in;
  logic [31:0]       rdata_out;
  logic              stall;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_we;
  logic              sram_re;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, addr_in, wdata_in, sram_rdata,
    output rdata_out, stall, sram_addr, sram_wdata, sram_we, sram_re
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, addr_in, wdata_in, sram_rdata,
    input  rdata_out, stall, sram_addr, sram_wdata, sram_we, sram_re
  );
endinterface

// File: rtl/en_reg.sv
// Generic enabled register with asynchronous active-high clear.
//   clk, rst : clock / async reset (q -> 0)
//   en, d    : load d into q when en
//   q        : registered value
module en_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mem_access_ctrl_wait_counter.sv
// Down-counter timing one SRAM access.
//   load : reload with WAIT_CYCLES-1 (takes priority over en)
//   en   : count down, saturating at zero
//   zero : counter is at zero (last access cycle)
module wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign zero = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= LOAD_VAL;
    else if (en && !zero) cnt <= cnt - CW'(1);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller for a fixed-latency SRAM.
// A load/store seen in IDLE is captured, the SRAM is strobed for WAIT_CYCLES
// cycles, then one DONE cycle lets the pipeline advance with rdata_out valid.
//   clk, rst : clock, async active-high reset
//   bus      : request / load-data / SRAM signals (slave side)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_W      = 16,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_ctrl_if.slave   bus
);
  localparam logic [31:0] BASE_W = 32'(BASE_ADDR);

  state_t            state, state_nxt;
  logic              req, cap_en, cnt_zero, rd_done;
  logic              op_nxt, op_q;
  logic [31:0]       byte_off;
  logic [ADDR_W-1:0] word_addr, addr_q;
  logic [31:0]       wdata_q, rdata_q;

  assign req    = bus.MEM_R_EN | bus.MEM_W_EN;
  assign cap_en = (state == ST_IDLE) & req;
  // Simultaneous read+write enables resolve to a read.
  assign op_nxt = bus.MEM_R_EN ? MEM_OP_RD : MEM_OP_WR;

  // Below-base addresses wrap modulo 2^ADDR_W words.
  assign byte_off  = bus.addr_in - BASE_W;
  assign word_addr = ADDR_W'(byte_off >> 2);

  en_reg #(.W(1))      u_op    (.clk(clk), .rst(rst), .en(cap_en), .d(op_nxt),       .q(op_q));
  en_reg #(.W(ADDR_W)) u_addr  (.clk(clk), .rst(rst), .en(cap_en), .d(word_addr),    .q(addr_q));
  en_reg #(.W(32))     u_wdata (.clk(clk), .rst(rst), .en(cap_en), .d(bus.wdata_in), .q(wdata_q));

  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cap_en),
    .en   (state == ST_ACCESS),
    .zero (cnt_zero)
  );

  // Load data is captured on the last access cycle and held across stores.
  assign rd_done = (state == ST_ACCESS) & cnt_zero & (op_q == MEM_OP_RD);
  en_reg #(.W(32)) u_rdata (.clk(clk), .rst(rst), .en(rd_done), .d(bus.sram_rdata), .q(rdata_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt_zero) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // stall covers the IDLE request cycle too, so the pipeline freezes
  // before the first SRAM cycle; gated by rst so reset forces it low.
  assign bus.stall      = ~rst & ((state == ST_ACCESS) | cap_en);
  assign bus.sram_re    = (state == ST_ACCESS) & (op_q == MEM_OP_RD);
  assign bus.sram_we    = (state == ST_ACCESS) & (op_q == MEM_OP_WR);
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.rdata_out  = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int W    = 5;
  localparam int AW   = 16;
  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(AW)) bus ();

  mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Initial SRAM image: word 1 holds DEADBEEF, everything else a hash.
  function automatic logic [31:0] init_word(logic [AW-1:0] a);
    if (a == 16'd1) return 32'hDEADBEEF;
    return ({16'h0, a} * 32'h9E3779B1) + 32'h01234567;
  endfunction

  // SRAM device model: combinational read, write on clock edge.
  logic [31:0] sram_mem [65536];
  bit          sram_vld [65536];
  always @(posedge clk) begin
    if (bus.sram_we) begin
      sram_mem[bus.sram_addr] <= bus.sram_wdata;
      sram_vld[bus.sram_addr] <= 1'b1;
    end
  end
  assign bus.sram_rdata = sram_vld[bus.sram_addr] ? sram_mem[bus.sram_addr]
                                                  : init_word(bus.sram_addr);

  // Reference model: architectural memory contents and last loaded value.
  logic [31:0] ref_mem [65536];
  bit          ref_vld [65536];
  logic [31:0] last_rd = '0;

  function automatic logic [AW-1:0] word_of(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return off[AW+1:2];
  endfunction

  typedef struct {
    bit          rd;
    logic [AW-1:0] word;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];

  bit mon_en = 1'b0;

  // Issue one memory instruction and hold it until the controller releases
  // the pipeline. scr: scramble inputs while the access is in flight.
  task automatic do_op(bit r, bit w, logic [31:0] a, logic [31:0] d, bit scr);
    exp_t e;
    bit   done;
    e.rd    = r;
    e.word  = word_of(a);
    e.wdata = d;
    if (r) begin
      e.rdata = ref_vld[e.word] ? ref_mem[e.word] : init_word(e.word);
      last_rd = e.rdata;
    end else begin
      ref_mem[e.word] = d;
      ref_vld[e.word] = 1'b1;
      e.rdata = last_rd;
    end
    q.push_back(e);
    @(posedge clk); #1;
    bus.MEM_R_EN = r; bus.MEM_W_EN = w; bus.addr_in = a; bus.wdata_in = d;
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!bus.stall) begin
        if (n == 0) chk("no_stall", 32'd0, 32'd1);
        done = 1'b1;
        break;
      end
      if (scr && n > 0) begin
        bus.MEM_R_EN = 1'($urandom); bus.MEM_W_EN = 1'($urandom);
        bus.addr_in  = $urandom;     bus.wdata_in = $urandom;
      end
    end
    if (!done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(int n);
    @(posedge clk); #1;
    bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
    bus.addr_in  = $urandom; bus.wdata_in = $urandom;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: detects each access by its stall window and checks it
  // against the expectation queued at issue time.
  bit   act = 1'b0;
  int   scnt, rcnt, wcnt;
  exp_t cur;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!act) begin
        if (bus.stall) begin
          act = 1'b1; scnt = 1; rcnt = 0; wcnt = 0;
          if (q.size() == 0) chk("unexpected_access", 32'd1, 32'd0);
          else cur = q.pop_front();
          chk("req_cycle_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
        end else if (bus.sram_re || bus.sram_we) begin
          chk("idle_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
        end
      end else if (bus.stall) begin
        scnt++;
        if (bus.sram_re) rcnt++;
        if (bus.sram_we) wcnt++;
        if (bus.sram_re || bus.sram_we) begin
          if (bus.sram_addr !== cur.word) chk("sram_addr", 32'(bus.sram_addr), 32'(cur.word));
          if (bus.sram_we && bus.sram_wdata !== cur.wdata) chk("sram_wdata", bus.sram_wdata, cur.wdata);
        end
      end else begin
        chk("stall_len", scnt, W + 1);
        chk("re_cycles", rcnt, cur.rd ? W : 0);
        chk("we_cycles", wcnt, cur.rd ? 0 : W);
        chk("done_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
        chk(cur.rd ? "load_data" : "rdata_hold", bus.rdata_out, cur.rdata);
        act = 1'b0;
      end
    end
  end

  initial begin
    bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b0;
    bus.addr_in  = 32'd1028; bus.wdata_in = '0;
    repeat (3) @(posedge clk); #1;
    // Reset state, with a request pending on the inputs.
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_strobes", {30'd0, bus.sram_re, bus.sram_we}, 32'd0);
    chk("rst_rdata", bus.rdata_out, 32'd0);
    chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_sram_wdata", bus.sram_wdata, 32'd0);
    bus.MEM_R_EN = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Reset in the middle of a store.
    @(posedge clk); #1;
    bus.MEM_W_EN = 1'b1; bus.addr_in = 32'd1024 + 40; bus.wdata_in = 32'hCAFEF00D;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_we", {31'd0, bus.sram_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, bus.sram_we}, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("mid_rst_rdata", bus.rdata_out, 32'd0);
    // The first access cycle already committed the write.
    ref_mem[10] = 32'hCAFEF00D; ref_vld[10] = 1'b1;
    bus.MEM_W_EN = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    do_op(1, 0, 32'd1028, 32'h0, 0);              // load word 1
    do_op(0, 1, 32'd1032, 32'h12345678, 0);       // store word 2
    do_op(0, 1, 32'd1036, 32'hA5A55A5A, 0);       // back-to-back store
    do_op(1, 0, 32'd1036 | 32'd3, 32'h0, 0);      // load, low bits ignored
    do_op(1, 1, 32'd1032, 32'hFFFFFFFF, 0);       // both enables: read only
    do_op(1, 0, 32'd1064, 32'h0, 0);              // reload aborted-store word
    idle(20);                                     // no requests
    do_op(0, 1, 32'd1020, 32'h0BADC0DE, 1);       // below base, scrambled inputs
    do_op(1, 0, 32'd1020, 32'h0, 1);

    for (int i = 0; i < 60; i++) begin
      bit r, w;
      r = 1'($urandom); w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      do_op(r, w, 32'(BASE - 16 + 4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
            $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    idle(5);
    chk("queue_empty", q.size(), 32'd0);
    chk("monitor_idle", {31'd0, act}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
